// File: rtl/mips_divider.sv
// ============================================================================
// Module   : mips_divider
// Brief    : Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU (LO=quotient, HI=remainder).
// Revision : 1.0
// ============================================================================
`default_nettype none

module mips_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_div;
  logic [WIDTH-1:0]   r_dividend;
  logic [c_CNT_W-1:0] r_count;
  logic               r_neg_quo;
  logic               r_neg_rem;
  logic               r_zero;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_dbz;

  logic             w_dd_neg;
  logic             w_dv_neg;
  logic [WIDTH-1:0] w_dd_abs;
  logic [WIDTH-1:0] w_dv_abs;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;

  // Operand magnitudes; the most-negative value maps onto 2^(WIDTH-1) as unsigned.
  assign w_dd_neg = is_signed & dividend[WIDTH-1];
  assign w_dv_neg = is_signed & divisor[WIDTH-1];
  assign w_dd_abs = w_dd_neg ? -dividend : dividend;
  assign w_dv_abs = w_dv_neg ? -divisor  : divisor;

  // Quotient register doubles as the dividend shift register.
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_div};
  assign w_borrow = w_diff[WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CALC;
      S_CALC:  if (r_count == '0) w_state_nxt = S_SIGN;
      S_SIGN:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_dividend  <= '0;
      r_count     <= '0;
      r_neg_quo   <= 1'b0;
      r_neg_rem   <= 1'b0;
      r_zero      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem      <= '0;
            r_quo      <= w_dd_abs;
            r_div      <= w_dv_abs;
            r_dividend <= dividend;
            r_count    <= c_CNT_W'(WIDTH - 1);
            r_neg_quo  <= w_dd_neg ^ w_dv_neg;
            r_neg_rem  <= w_dd_neg;
            r_zero     <= (divisor == '0);
          end
        end
        S_CALC: begin
          r_rem   <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
          r_quo   <= {r_quo[WIDTH-2:0], ~w_borrow};
          r_count <= r_count - c_CNT_W'(1);
        end
        S_SIGN: begin
          // Divide-by-zero reports the raw dividend with no sign fixup.
          if (r_zero) begin
            r_quotient  <= '1;
            r_remainder <= r_dividend;
            r_dbz       <= 1'b1;
          end else begin
            r_quotient  <= r_neg_quo ? -r_quo : r_quo;
            r_remainder <= r_neg_rem ? -r_rem : r_rem;
            r_dbz       <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_mips_divider.sv
// ============================================================================
// Module   : tb_mips_divider
// Brief    : Directed self-checking bench for mips_divider (WIDTH=32).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mips_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  mips_divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Pulse start for one edge (E0); returns at the negedge after E0.
  task automatic launch(input bit s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges from E0 (inclusive) until done is seen, and busy cycles; bounded at 200.
  task automatic wait_done(output int lat, output int bcyc);
    lat = 1; bcyc = 0;
    while (lat < 200) begin
      if (busy) bcyc++;
      if (done) break;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL reset_q: got %h expected 0", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL reset_r: got %h expected 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    reset = 1'b0;
  endtask

  task automatic test_divu_basic;
    int lat, bcyc;
    launch(1'b0, 32'd100, 32'd7);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %b expected 1", busy); end
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL basic_no_leak: got %h expected 0", quotient); end
    wait_done(lat, bcyc);
    checks++; if (lat !== 34) begin errors++; $display("FAIL basic_latency: got %0d expected 34", lat); end
    checks++; if (bcyc !== 34) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 34", bcyc); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL basic_q: got %h expected %h", quotient, 32'd14); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL basic_r: got %h expected %h", remainder, 32'd2); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %b expected 0", div_by_zero); end
    @(posedge clk); @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL basic_q_held: got %h expected %h", quotient, 32'd14); end
  endtask

  // Signed sign rules, overflow, unsigned edge cases and divide-by-zero.
  task automatic test_divide_table;
    bit          t_s [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] t_a [9] = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'h80000000, 32'h80000000,
                             32'hFFFFFFFF, 32'd1234, 32'd1234, 32'hFFFFFFFB};
    logic [31:0] t_b [9] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'd1, 32'd0, 32'd0, 32'd0};
    logic [31:0] t_q [9] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'd3, 32'h80000000, 32'd0,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] t_r [9] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 32'h80000000,
                             32'd0, 32'd1234, 32'd1234, 32'hFFFFFFFB};
    bit          t_z [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      int lat, bcyc;
      launch(t_s[i], t_a[i], t_b[i]);
      wait_done(lat, bcyc);
      checks++; if (lat !== 34) begin errors++; $display("FAIL table%0d_latency: got %0d expected 34", i, lat); end
      checks++; if (bcyc !== 34) begin errors++; $display("FAIL table%0d_busy: got %0d expected 34", i, bcyc); end
      checks++; if (quotient !== t_q[i]) begin errors++; $display("FAIL table%0d_q: got %h expected %h", i, quotient, t_q[i]); end
      checks++; if (remainder !== t_r[i]) begin errors++; $display("FAIL table%0d_r: got %h expected %h", i, remainder, t_r[i]); end
      checks++; if (div_by_zero !== t_z[i]) begin errors++; $display("FAIL table%0d_dbz: got %b expected %b", i, div_by_zero, t_z[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int lat, bcyc;
    launch(1'b0, 32'd100, 32'd7);
    lat = 1;
    while (lat < 200) begin
      if (done) break;
      if (lat == 5) begin
        start = 1'b1; is_signed = 1'b1; dividend = 32'd9; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency: got %0d expected 34", lat); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL b2b_first_q: got %h expected %h", quotient, 32'd14); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL b2b_first_r: got %h expected %h", remainder, 32'd2); end
    // Start held through the done cycle: ignored there, accepted on the following edge.
    start = 1'b1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done_start_ignored: busy got %b expected 0", busy); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL b2b_held_idle: got %h expected %h", quotient, 32'd14); end
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_busy: got %b expected 1", busy); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL b2b_held_busy: got %h expected %h", remainder, 32'd2); end
    wait_done(lat, bcyc);
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 34", lat); end
    checks++; if (quotient !== 32'd3) begin errors++; $display("FAIL b2b_second_q: got %h expected %h", quotient, 32'd3); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL b2b_second_r: got %h expected 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL b2b_second_dbz: got %b expected 0", div_by_zero); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat, bcyc, pulses;
    launch(1'b1, 32'hFFFFFFF9, 32'd2);
    lat = 1;
    while (lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done); end
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL rstmid_q: got %h expected 0", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL rstmid_r: got %h expected 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL rstmid_dbz: got %b expected 0", div_by_zero); end
    pulses = 0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (done || busy) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d active cycles expected 0", pulses); end
    launch(1'b0, 32'd1000, 32'd10);
    wait_done(lat, bcyc);
    checks++; if (lat !== 34) begin errors++; $display("FAIL rstmid_latency: got %0d expected 34", lat); end
    checks++; if (quotient !== 32'd100) begin errors++; $display("FAIL rstmid_q_after: got %h expected %h", quotient, 32'd100); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL rstmid_r_after: got %h expected 0", remainder); end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_divide_table();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
